serial_tx_ctrl: RTL
===================

# serial_tx_ctrl

Frame-level transmit controller that sits around the 8-bit universal shift register (`shiftRegister`). It accepts a byte over a valid/ready handshake, loads it into the register, and issues one shift-right per bit period, taking the serial bit from `sr_q[0]`. It drives a UART-style line: start bit, 8 data bits LSB-first, optional parity, and stop bit.

## Interface
- `DIV`, 16, clock cycles per bit period; must be ≥ 2.
- `PAR_EN`, 0, 1 inserts a parity bit after the data bits.
- `PAR_ODD`, 0, parity sense when `PAR_EN`=1: 0 = even, 1 = odd.
- `c`  in  1  clock; all state changes on its rising edge.
- `nrst`  in  1  reset; asynchronous, active-low.
- `din`  in  8  byte to send; sampled only at accept.
- `valid`  in  1  `din` is valid.
- `ready`  out  1  controller can accept a byte.
- `sr_d`  out  8  parallel-load data to the shift register.
- `sr_l`, `sr_r`  out  1 each  shift register mode selects.
- `sr_i`  out  1  serial input to the shift register; constant 0.
- `sr_q`  in  8  shift register contents.
- `tx`  out  1  serial line; idles high.
- `busy`  out  1  a frame is in progress.
- `done`  out  1  one-cycle pulse at the end of a frame.

## Operation
- Shift register mode encoding, {`sr_r`,`sr_l`}:
  - 00: hold.
  - 01: shift toward LSB; `q[n]<=q[n+1]`, `q[7]<=sr_i`.
  - 10: shift toward MSB (unused here).
  - 11: parallel load of `sr_d`.
- FSM states: IDLE → LOAD → START → DATA → [PARITY] → STOP → IDLE.
- IDLE:
  - `ready`=1, `tx`=1, mode 00.
  - On `valid`&`ready`: register `din` into `sr_d`, compute parity, go to LOAD.
- LOAD: lasts 1 cycle; mode 11. The register captures `sr_d` at the closing edge.
- START: `tx`=0 for `DIV` cycles.
- DATA:
  - `tx`=`sr_q[0]`; the bit counter runs 0..7.
  - In the last cycle of each bit period (tick), mode = 01 so the next bit reaches `sr_q[0]`.
  - This gives exactly 8 shift cycles per frame.
  - After bit 7 go to PARITY if `PAR_EN`, otherwise STOP.
- PARITY: `tx` = `^byte` XOR `PAR_ODD` for `DIV` cycles.
- STOP: `tx`=1 for `DIV` cycles, then go to IDLE. `done`=1 in the first IDLE cycle.
- Baud counter:
  - Width is `$clog2(DIV)`; it counts 0..`DIV`-1.
  - It clears on entering START and wraps at each tick.
  - It is idle and held at 0 in IDLE and LOAD.
- `valid` while `ready`=0 is ignored; `din` does not need to be held after accept.
- The shift register has no reset. Its contents are don't-care until LOAD, and the controller holds mode 00 at all other times.

## Timing
- Reset values: state IDLE, `tx`=1, `ready`=1, `busy`=0, `done`=0, `sr_l`=`sr_r`=0, `sr_i`=0, `sr_d`=0, counters 0.
- Asserting `nrst` mid-frame immediately forces IDLE and `tx`=1, with no `done` pulse.
- The accept edge is cycle 0:
  - LOAD is cycle 1.
  - The start bit begins at cycle 2.
  - IDLE (`done`=1, `ready`=1) is reached at cycle 2+`DIV`×(10+`PAR_EN`).
- `tx`, `ready`, `busy` and `done` are registered or decoded from state only, never from `valid`, so there is no combinational path from input to output.
- `sr_l`/`sr_r` are decoded from state and the tick; they are valid for the whole cycle before the sampling edge.
- Back-to-back frames with `valid` held high:
  - The next accept happens in the `done` cycle.
  - The line stays high for the stop bit plus 2 cycles (IDLE, LOAD) between frames.
- `busy` = not IDLE; it is high from LOAD through the last STOP cycle.

## Structure
- Package `serial_pkg` holds:
  - the state enum;
  - the mode constants `SR_HOLD`, `SR_SHR`, `SR_SHL`, `SR_LOAD`;
  - the parity-sense constants.
- Sub-module `baud_tick`, one instance:
  - parameter `DIV`; inputs `c`, `nrst`, `clr`, `en`; output `tick`;
  - `tick` is high when the count equals `DIV`-1.
- Bench wiring: `serial_tx_ctrl` connects to a real `shiftRegister` instance on the same `c`.

## Test plan
- `DIV`=4, no parity, send 0xA5 → `tx` per bit 0,1,0,1,0,0,1,0,1,1, each held 4 cycles; `done` at cycle 42; exactly one LOAD cycle with `sr_d`=0xA5; exactly 8 mode-01 cycles.
- `DIV`=4, `PAR_EN`=1, send 0x07: with `PAR_ODD`=0 the parity bit is 1; with `PAR_ODD`=1 it is 0; frame ends at cycle 46.
- `valid` held high with 0x00 then 0xFF → the second accept happens in the first frame's `done` cycle; there are 6 high cycles between the two start bits (4 stop + IDLE + LOAD); `din` changes outside accept are ignored.
- Drop `nrst` during DATA bit 3 → `tx`=1, `ready`=1, `busy`=0 asynchronously; no `done`; the next send of 0x3C after reset is correct.
- `valid` pulsed while `busy` → not accepted; no frame corruption; `ready` stays 0 until IDLE.

Source files
------------

// File: rtl/serial_pkg.sv
// Shared types and constants for the serial transmit controller.
package serial_pkg;

    // Frame sequencer states
    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_START,
        S_DATA,
        S_PARITY,
        S_STOP
    } state_t;

    // Shift register mode encoding, {sr_r, sr_l}
    localparam logic [1:0] SR_HOLD = 2'b00;
    localparam logic [1:0] SR_SHR  = 2'b01;
    localparam logic [1:0] SR_SHL  = 2'b10;
    localparam logic [1:0] SR_LOAD = 2'b11;

    // Parity sense
    localparam logic PARITY_EVEN = 1'b0;
    localparam logic PARITY_ODD  = 1'b1;

endpackage

// File: rtl/serial_tx_ctrl_if.sv
// Byte handshake between a producer and the transmit controller.
interface serial_tx_ctrl_if;
    import serial_pkg::*;

    logic [7:0] din;
    logic       valid;
    logic       ready;

    modport master (output din, output valid, input ready);
    modport slave  (input din, input valid, output ready);

endinterface

// File: rtl/baud_tick.sv
// Bit-period counter: counts 0..DIV-1 while enabled, tick on the last count.
module baud_tick
    import serial_pkg::*;
#(
    parameter int DIV = 16
) (
    input  logic c,
    input  logic nrst,
    input  logic clr,
    input  logic en,
    output logic tick
);

    localparam int W = (DIV > 1) ? $clog2(DIV) : 1;

    logic [W-1:0] cnt;

    assign tick = (cnt == W'(DIV - 1));

    // Held at zero when idle or cleared, wraps at each tick
    always_ff @(posedge c or negedge nrst) begin
        if (!nrst) begin
            cnt <= '0;
        end else if (clr || !en || tick) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end

endmodule

// File: rtl/shiftRegister.sv
// 8-bit universal shift register (no reset); mode {r,l}: hold/shr/shl/load.
module shiftRegister (
    input  logic       c,
    input  logic       l,
    input  logic       r,
    input  logic       i,
    input  logic [7:0] d,
    output logic [7:0] q
);

    // Mode-selected update of the register contents
    always_ff @(posedge c) begin
        case ({r, l})
            2'b01:   q <= {i, q[7:1]};
            2'b10:   q <= {q[6:0], i};
            2'b11:   q <= d;
            default: q <= q;
        endcase
    end

endmodule

// File: rtl/serial_tx_ctrl.sv
// UART-style frame transmitter driving an external 8-bit shift register.
module serial_tx_ctrl
    import serial_pkg::*;
#(
    parameter int DIV     = 16,
    parameter bit PAR_EN  = 1'b0,
    parameter bit PAR_ODD = 1'b0
) (
    input  logic             c,
    input  logic             nrst,
    serial_tx_ctrl_if.slave  host,
    output logic [7:0]       sr_d,
    output logic             sr_l,
    output logic             sr_r,
    output logic             sr_i,
    input  logic [7:0]       sr_q,
    output logic             tx,
    output logic             busy,
    output logic             done
);

    state_t     state;
    logic       ready;
    logic       par;
    logic [2:0] bit_cnt;
    logic       tick;
    logic       baud_clr;
    logic       baud_en;
    logic [1:0] mode;

    assign host.ready = ready;
    assign sr_i       = 1'b0;

    // The baud counter restarts on the way into START so the start bit is DIV long
    assign baud_clr = (state == S_LOAD);
    assign baud_en  = (state == S_START) || (state == S_DATA) ||
                      (state == S_PARITY) || (state == S_STOP);

    baud_tick #(.DIV(DIV)) u_baud (
        .c    (c),
        .nrst (nrst),
        .clr  (baud_clr),
        .en   (baud_en),
        .tick (tick)
    );

    // Shift register mode: load once, then one shift-right per data bit tick
    always_comb begin
        mode = SR_HOLD;
        if (state == S_LOAD) begin
            mode = SR_LOAD;
        end else if ((state == S_DATA) && tick) begin
            mode = SR_SHR;
        end
    end

    assign {sr_r, sr_l} = mode;

    // Frame sequencer with registered line and status outputs
    always_ff @(posedge c or negedge nrst) begin
        if (!nrst) begin
            state   <= S_IDLE;
            tx      <= 1'b1;
            ready   <= 1'b1;
            busy    <= 1'b0;
            done    <= 1'b0;
            sr_d    <= '0;
            par     <= 1'b0;
            bit_cnt <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (host.valid && ready) begin
                        sr_d  <= host.din;
                        par   <= (^host.din) ^ PAR_ODD;
                        ready <= 1'b0;
                        busy  <= 1'b1;
                        state <= S_LOAD;
                    end
                end
                S_LOAD: begin
                    state   <= S_START;
                    tx      <= 1'b0;
                    bit_cnt <= '0;
                end
                S_START: begin
                    if (tick) begin
                        state <= S_DATA;
                        tx    <= sr_q[0];
                    end
                end
                S_DATA: begin
                    if (tick) begin
                        if (bit_cnt == 3'd7) begin
                            if (PAR_EN) begin
                                state <= S_PARITY;
                                tx    <= par;
                            end else begin
                                state <= S_STOP;
                                tx    <= 1'b1;
                            end
                        end else begin
                            bit_cnt <= bit_cnt + 3'd1;
                            // The register shifts on this same edge, so sr_q[1] is the next bit
                            tx      <= sr_q[1];
                        end
                    end
                end
                S_PARITY: begin
                    if (tick) begin
                        state <= S_STOP;
                        tx    <= 1'b1;
                    end
                end
                S_STOP: begin
                    if (tick) begin
                        state <= S_IDLE;
                        ready <= 1'b1;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                    end
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule
